otter_wb_arbiter: RTL and testbench

- Writeback arbiter feeding the OTTER register file's single write port (wd/en/wa), which commits on the falling clock edge.
- Merges two sources:
  - in-order pipeline writeback: no backpressure, normal priority;
  - late-result source (load unit, mul/div): valid/ready handshake, buffered in a small FIFO.
- Also provides a pending-write query so the hazard unit can stall reads of registers with buffered writes.

---
 rtl/otter_wb_arbiter_if.sv | 29 ++
 rtl/otter_wb_arbiter.sv | 100 ++++++++++
 tb/tb_otter_wb_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/otter_wb_arbiter_if.sv
// Bus bundle between the OTTER writeback arbiter and its requesters, hazard unit and register file.
`timescale 1ns/1ps
interface otter_wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              pipe_we;
  logic [4:0]        pipe_wa;
  logic [DATA_W-1:0] pipe_wd;
  logic              pipe_stall;
  logic              late_valid;
  logic              late_ready;
  logic [4:0]        late_wa;
  logic [DATA_W-1:0] late_wd;
  logic [4:0]        q_adr;
  logic              q_pend;
  logic              rf_en;
  logic [4:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, late_valid, late_wa, late_wd, q_adr,
    output pipe_stall, late_ready, q_pend, rf_en, rf_wa, rf_wd
  );

  modport master (
    output pipe_we, pipe_wa, pipe_wd, late_valid, late_wa, late_wd, q_adr,
    input  pipe_stall, late_ready, q_pend, rf_en, rf_wa, rf_wd
  );
endinterface

// File: rtl/otter_wb_arbiter.sv
// Merges in-order pipeline writebacks with buffered late results onto the single
// register-file write port, with starvation forcing and a pending-write query.
`timescale 1ns/1ps
module otter_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int DATA_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  otter_wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [4:0]        fifo_wa [DEPTH];
  logic [DATA_W-1:0] fifo_wd [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt;

  logic empty, full, pipe_req, force_head, pop, push, pipe_win;
  logic fifo_hit;
  logic [PTR_W-1:0] off;

  always_comb begin
    empty      = (count == '0);
    full       = (count == DEPTH_C);
    pipe_req   = bus.pipe_we && (bus.pipe_wa != 5'd0);
    force_head = !empty && (starve_cnt == LIMIT_C);
    pop        = force_head || (!pipe_req && !empty);
    pipe_win   = pipe_req && !force_head;
    // x0 results are handshaken but never stored
    push       = bus.late_valid && !full && (bus.late_wa != 5'd0);
  end

  assign bus.late_ready = !full;
  assign bus.pipe_stall = pipe_req && force_head;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    fifo_hit = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(off) < count) && (fifo_wa[i] == bus.q_adr)) fifo_hit = 1'b1;
    end
  end

  assign bus.q_pend = (bus.q_adr != 5'd0) &&
                      (fifo_hit || (bus.rf_en && (bus.rf_wa == bus.q_adr)));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= bus.late_wa;
      fifo_wd[wr_ptr] <= bus.late_wd;
    end
  end

  // Output register stage: winner is presented one cycle after arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      bus.rf_en  <= 1'b0;
      bus.rf_wa  <= '0;
      bus.rf_wd  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (pop || empty)
        starve_cnt <= '0;
      else if (pipe_win && (starve_cnt != LIMIT_C))
        starve_cnt <= starve_cnt + SC_W'(1);

      if (pop) begin
        bus.rf_en <= 1'b1;
        bus.rf_wa <= fifo_wa[rd_ptr];
        bus.rf_wd <= fifo_wd[rd_ptr];
      end else if (pipe_win) begin
        bus.rf_en <= 1'b1;
        bus.rf_wa <= bus.pipe_wa;
        bus.rf_wd <= bus.pipe_wd;
      end else begin
        bus.rf_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Directed bench for otter_wb_arbiter: expected register-file writes are queued as
// stimulus is applied and retired by a falling-edge monitor.
`timescale 1ns/1ps
module tb_otter_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [36:0] sb [$];

  always #5 clk = ~clk;

  otter_wb_arbiter_if #(.DATA_W(32)) bus ();

  otter_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd);
    bus.pipe_we    = pwe;
    bus.pipe_wa    = pwa;
    bus.pipe_wd    = pwd;
    bus.late_valid = lv;
    bus.late_wa    = lwa;
    bus.late_wd    = lwd;
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
    sb.push_back({wa, wd});
  endtask

  // Retire every register-file write against the scoreboard
  always @(negedge clk) begin
    if (bus.rf_en === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write: observed wa=%0d wd=%h expected no write", bus.rf_wa, bus.rf_wd);
      end
      if (sb.size() != 0) begin
        logic [36:0] e;
        e = sb.pop_front();
        check("sb_wa", {27'd0, bus.rf_wa}, {27'd0, e[36:32]});
        check("sb_wd", bus.rf_wd, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic qexp [6];
    qexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset then idle
    rst = 1'b1;
    bus.q_adr = 5'd0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_rf_en", bus.rf_en, 0);
    check("rst_rf_wa", bus.rf_wa, 0);
    check("rst_rf_wd", bus.rf_wd, 0);
    check("rst_late_ready", bus.late_ready, 1);
    check("rst_pipe_stall", bus.pipe_stall, 0);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.q_adr = 5'(a);
      #1;
      check("idle_q_pend", bus.q_pend, 0);
      tick();
      check("idle_rf_en", bus.rf_en, 0);
    end

    // Pipe only, then a write to x0
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("pipe_stall0", bus.pipe_stall, 0);
    expect_wr(5, 32'hDEADBEEF);
    tick();
    check("pipe_rf_en", bus.rf_en, 1);
    check("pipe_rf_wa", bus.rf_wa, 5);
    check("pipe_rf_wd", bus.rf_wd, 32'hDEADBEEF);
    bus.q_adr = 5'd5;
    drive(1, 0, 32'h12345678, 0, 0, 0);
    check("q_pend_outreg", bus.q_pend, 1);
    tick();
    check("x0_rf_en", bus.rf_en, 0);
    check("q_pend_after", bus.q_pend, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Late fill with pipe idle: drains on consecutive cycles
    bus.q_adr = 5'd3;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(0, 0, 0, 1, 5'(k + 1), 32'h10 + k);
      else       drive(0, 0, 0, 0, 0, 0);
      check("fill_late_ready", bus.late_ready, 1);
      check("fill_q_pend3", bus.q_pend, qexp[k]);
      check("fill_rf_en", bus.rf_en, (k >= 2) ? 1 : 0);
      if (k < 4) expect_wr(5'(k + 1), 32'h10 + k);
      tick();
    end
    check("fill_done_rf_en", bus.rf_en, 0);

    // Fill to full behind a busy pipe; full cycle pops but refuses a push
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'(20 + c), 32'hA0 + c, 1, 5'(c + 1), 32'h10 + c);
      check("busy_late_ready", bus.late_ready, 1);
      check("busy_pipe_stall", bus.pipe_stall, 0);
      expect_wr(5'(20 + c), 32'hA0 + c);
      tick();
    end
    drive(1, 24, 32'hA4, 1, 6, 32'h14);
    check("full_late_ready", bus.late_ready, 0);
    check("full_pipe_stall", bus.pipe_stall, 1);
    expect_wr(1, 32'h10);
    tick();
    drive(1, 24, 32'hA4, 1, 6, 32'h14);
    check("refill_late_ready", bus.late_ready, 1);
    check("refill_pipe_stall", bus.pipe_stall, 0);
    expect_wr(24, 32'hA4);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("refull_late_ready", bus.late_ready, 0);
    expect_wr(2, 32'h11);
    tick();
    check("drain_late_ready", bus.late_ready, 1);
    expect_wr(3, 32'h12);
    tick();
    expect_wr(4, 32'h13);
    tick();
    expect_wr(6, 32'h14);
    tick();
    tick();
    check("busy_done_rf_en", bus.rf_en, 0);

    // Late result to x0 is accepted and dropped
    drive(0, 0, 0, 1, 0, 32'hFFFF);
    check("x0_late_ready", bus.late_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("x0_late_rf_en", bus.rf_en, 0);

    // Starvation: head wa=7 loses three times, then forces priority
    bus.q_adr = 5'd7;
    drive(1, 9, 32'h900, 1, 7, 32'h77);
    check("starve_stall_s0", bus.pipe_stall, 0);
    expect_wr(9, 32'h900);
    tick();
    for (int s = 1; s < 4; s++) begin
      drive(1, 9, 32'h900 + s, 0, 0, 0);
      check("starve_stall", bus.pipe_stall, 0);
      check("starve_q_pend7", bus.q_pend, 1);
      expect_wr(9, 32'h900 + s);
      tick();
    end
    drive(1, 9, 32'h904, 0, 0, 0);
    check("starve_force_stall", bus.pipe_stall, 1);
    expect_wr(7, 32'h77);
    tick();
    check("starve_rf_wa7", bus.rf_wa, 7);
    drive(1, 9, 32'h904, 0, 0, 0);
    check("starve_resume_stall", bus.pipe_stall, 0);
    expect_wr(9, 32'h904);
    tick();
    check("starve_rf_wa9", bus.rf_wa, 9);
    check("starve_rf_wd", bus.rf_wd, 32'h904);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset with three late results buffered
    for (int r = 0; r < 3; r++) begin
      drive(1, 11, 32'hB0 + r, 1, 5'(12 + r), 32'hC0 + r);
      expect_wr(11, 32'hB0 + r);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    bus.q_adr = 5'd13;
    #1;
    check("pre_rst_q_pend", bus.q_pend, 1);
    tick();
    check("mid_rst_rf_en", bus.rf_en, 0);
    check("mid_rst_rf_wa", bus.rf_wa, 0);
    check("mid_rst_rf_wd", bus.rf_wd, 0);
    check("mid_rst_late_ready", bus.late_ready, 1);
    check("mid_rst_pipe_stall", bus.pipe_stall, 0);
    for (int a = 12; a < 15; a++) begin
      bus.q_adr = 5'(a);
      #1;
      check("mid_rst_q_pend", bus.q_pend, 0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_rf_en", bus.rf_en, 0);
    tick();
    check("post_rst_rf_en2", bus.rf_en, 0);
    check("post_rst_late_ready", bus.late_ready, 1);
    tick();

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
